multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Moore-style control FSM sequencing the shared multicycle RV32 datapath (one ALU, one unified memory, IR/OldPC/ALUOut/Data regs).
// - Decodes lw/sw/R-type/beq over several cycles. Drives mux selects and write enables.
// - Handshakes with unified memory via mem_req/mem_ready. Aborts hung accesses with a timeout.
// PARAMETERS
// - MEM_TIMEOUT  default 15  max wait cycles per memory access before abort; 0 = never time out
// - CNT_W        default 4   wait-counter width; must hold MEM_TIMEOUT
// PORTS
// - clk        in   1  rising-edge clock
// - rst_n      in   1  asynchronous, active-low reset
// - op         in   7  IR[6:0] opcode
// - Zero       in   1  ALU zero flag
// - mem_ready  in   1  memory completes current access this cycle
// - mem_req    out  1  memory access active
// - AdrSrc     out  1  0 = PC, 1 = ALUOut as memory address
// - MemWrite   out  1  store strobe (qualified by mem_req)
// - IRWrite    out  1  load IR and OldPC
// - PCWrite    out  1  load PC from Result
// - RegWrite   out  1  register-file write
// - ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
// - ALUSrcA    out  2  00 PC, 01 OldPC, 10 rd1
// - ALUSrcB    out  2  00 rd2, 01 imm, 10 const 4
// - ALUOp      out  2  00 add, 01 sub (branch), 10 funct-decoded
// - ImmSrc     out  2  00 I, 01 S, 10 B, 11 J
// - illegal_op out  1  one-cycle pulse in DECODE for an unsupported opcode
// - bus_err    out  1  one-cycle pulse when a memory access times out
// - state_o    out  4  current state encoding (debug)
// BEHAVIOUR
// - Reset: state = FETCH, wait counter = 0. All outputs 0 while rst_n low; FETCH outputs apply from first clk after release.
// - Unlisted outputs are 0 in each state. ImmSrc decodes from op in every state (lw 00, sw 01, beq 10, jal 11, else 00).
// - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//   IRWrite = PCWrite = mem_ready. mem_ready -> DECODE, else stay.
// - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target to ALUOut).
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BEQ; else illegal_op=1 -> FETCH.
// - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
// - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. mem_ready -> MEMWB.
// - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
// - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. mem_ready -> FETCH.
// - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
// - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
// - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
// - Latency with mem_ready=1: lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2.
// - Wait counter: increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0; clears on any state change.
//   If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT with mem_ready=0: bus_err=1, IRWrite/PCWrite/MemWrite forced 0 that cycle, -> FETCH (PC unchanged).
//   mem_ready in the timeout cycle wins: normal completion, no bus_err.
//   Counter saturates; no wrap.
// - Async reset mid-instruction: immediate return to FETCH, outputs 0. No partial register or PC write after release.
// CONFIGURATION
// - RV_IMM_JAL_EN defined: adds EXECI and JAL states.
//   - DECODE: 0010011 -> EXECI (ALUSrcA=10, ALUSrcB=01, ALUOp=10) -> ALUWB.
//   - DECODE: 1101111 -> JAL (ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1) -> ALUWB (rd = OldPC+4).
// - RV_IMM_JAL_EN undefined: both opcodes take the illegal path (illegal_op pulse, -> FETCH); states absent.
// TESTING
// - Reset release, op=0110011, mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB. RegWrite=1 only in cycle 4, ALUOp=10 in EXECR.
// - op=0000011, mem_ready held 0 for 3 cycles in MEMREAD -> stays MEMREAD 4 cycles, mem_req=AdrSrc=1. MEMWB has ResultSrc=01, RegWrite=1.
// - op=1100011, Zero=1 then Zero=0 -> PCWrite=1 in BEQ, then PCWrite=0 in BEQ. Each returns to FETCH after 3 cycles.
// - FETCH, mem_ready=0 for 16 cycles, MEM_TIMEOUT=15 -> bus_err pulse on 16th cycle, IRWrite=PCWrite=0, state FETCH, counter 0.
// - op=1111111 -> illegal_op=1 in DECODE, FETCH next. op=1101111 without RV_IMM_JAL_EN -> same; with it -> JAL,ALUWB, PCWrite=1.
// - rst_n low during MEMWRITE with MemWrite=1 -> MemWrite=0 immediately (async). After release: state_o=FETCH, no store issued.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a shared-datapath multicycle RV32 core (one ALU, one unified
//   memory, IR/OldPC/ALUOut/Data registers). Sequences lw/sw/R-type/beq over several
//   cycles, handshakes with memory via mem_req/mem_ready and aborts hung accesses.
//
//   Optional feature macro: RV_IMM_JAL_EN adds EXECI (OP-IMM) and JAL states; when it is
//   undefined both opcodes take the illegal-opcode path.
//
// Parameters
//   MEM_TIMEOUT : max wait cycles per memory access before abort (0 = never abort)
//   CNT_W       : wait-counter width, must hold MEM_TIMEOUT
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   op                   : IR[6:0] opcode
//   Zero                 : ALU zero flag
//   mem_ready            : memory completes the current access this cycle
//   mem_req, AdrSrc      : memory access active, address select (0 PC, 1 ALUOut)
//   MemWrite             : store strobe
//   IRWrite, PCWrite     : IR/OldPC load, PC load
//   RegWrite             : register-file write
//   ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc : datapath selects
//   illegal_op, bus_err  : one-cycle error pulses
//   state_o              : current state encoding (debug)
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJalImm = 7'b1101111; // J-type immediate select only
`ifdef RV_IMM_JAL_EN
  localparam logic [6:0] OpImm = 7'b0010011;
`endif

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StBeq      = 4'd8
`ifdef RV_IMM_JAL_EN
    ,
    StExecI    = 4'd9,
    StJal      = 4'd10
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Low from reset until the first clock edge after release: keeps every output at 0 in
  // that window and stops the FSM from acting on inputs it never requested.
  logic             run_q;
  logic             mem_wait;
  logic             timeout_hit;

  assign mem_wait    = run_q &&
                       (state_q == StFetch || state_q == StMemRead || state_q == StMemWrite);
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready && (cnt_q == TimeoutCnt);
  assign state_o     = run_q ? state_q : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Wait counter: clears on any state change and on an abort (FETCH -> FETCH), saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_q || (state_d != state_q) || timeout_hit) begin
      cnt_d = '0;
    end else if (mem_wait && !mem_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    bus_err    = 1'b0;

    case (op)
      OpSw:     ImmSrc = 2'b01;
      OpBeq:    ImmSrc = 2'b10;
      OpJalImm: ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
        end
      end
      StDecode: begin
        // OldPC + imm precomputes the branch target into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpBeq:      state_d = StBeq;
`ifdef RV_IMM_JAL_EN
          OpImm:      state_d = StExecI;
          OpJalImm:   state_d = StJal;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OpSw)      state_d = StMemWrite;
        else if (op == OpLw) state_d = StMemRead;
        else                 state_d = StFetch;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !timeout_hit;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = Zero;
        state_d = StFetch;
      end
`ifdef RV_IMM_JAL_EN
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StJal: begin
        // PC <- target held in ALUOut; ALU forms OldPC + 4 for the link write in ALUWB.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = StAluWb;
      end
`endif
      default: state_d = StFetch;
    endcase

    if (!run_q) begin
      state_d    = StFetch;
      mem_req    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      ImmSrc     = 2'b00;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int unsigned TO = 15;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op;
  logic       zero_i, mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal_op, bus_err;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state_o;
  logic [17:0] got;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(zero_i), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_op(illegal_op),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign got = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, ImmSrc, illegal_op, bus_err};

  // Phase of an instruction as the architecture describes it.
  typedef enum {PF, PD, PMa, PMr, PMwb, PMw, PEx, PAwb, PBeq, PExi, PJal} ph_e;
  typedef struct {
    ph_e        ph;
    logic [6:0] op;
    bit         rdy;
    bit         z;
    bit         to;
  } cyc_t;

  cyc_t       q[$];
  cyc_t       cur;
  int         errors = 0;
  int         checks = 0;
  bit         active = 1'b0;
  logic [6:0] man_op = OpSw;
  bit         man_rdy = 1'b0;
  bit         man_z = 1'b0;

  task automatic check(input string name, input logic [17:0] g, input logic [17:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, g, e, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] o);
`ifdef RV_IMM_JAL_EN
    return o inside {OpLw, OpSw, OpR, OpBeq, OpImm, OpJal};
`else
    return o inside {OpLw, OpSw, OpR, OpBeq};
`endif
  endfunction

  // Expected output vector for one cycle of a given phase.
  function automatic logic [17:0] expect_out(input cyc_t c);
    logic req, adr, mw, irw, pcw, rw, ill, be;
    logic [1:0] rs, sa, sb, aop, imm;
    {req, adr, mw, irw, pcw, rw, ill, be} = '0;
    {rs, sa, sb, aop} = '0;
    imm = (c.op == OpSw) ? 2'b01 : (c.op == OpBeq) ? 2'b10 : (c.op == OpJal) ? 2'b11 : 2'b00;
    case (c.ph)
      PF:   begin req = 1; sb = 2; rs = 2; irw = c.rdy; pcw = c.rdy; be = c.to; end
      PD:   begin sa = 1; sb = 1; ill = !legal(c.op); end
      PMa:  begin sa = 2; sb = 1; end
      PMr:  begin req = 1; adr = 1; be = c.to; end
      PMwb: begin rs = 1; rw = 1; end
      PMw:  begin req = 1; adr = 1; mw = !c.to; be = c.to; end
      PEx:  begin sa = 2; aop = 2; end
      PAwb: rw = 1;
      PBeq: begin sa = 2; aop = 1; pcw = c.z; end
      PExi: begin sa = 2; sb = 1; aop = 2; end
      PJal: begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    return {req, adr, mw, irw, pcw, rw, rs, sa, sb, aop, imm, ill, be};
  endfunction

  task automatic push(input ph_e ph, input logic [6:0] o);
    cyc_t c;
    c.ph = ph; c.op = o; c.rdy = 1'($urandom); c.z = 1'($urandom); c.to = 1'b0;
    q.push_back(c);
  endtask

  // Memory access that completes after w not-ready cycles, or aborts on the (TO+1)th cycle.
  task automatic mem_phase(input ph_e ph, input logic [6:0] o, input int w, output bit done);
    cyc_t c;
    done = 1'b0;
    for (int i = 0; i <= int'(TO); i++) begin
      c.ph = ph; c.op = o; c.z = 1'($urandom);
      c.rdy = (i == w);
      c.to  = !c.rdy && (i == int'(TO));
      q.push_back(c);
      if (c.rdy) begin done = 1'b1; return; end
      if (c.to) return;
    end
  endtask

  task automatic gen_instr(input logic [6:0] o, input int wf, input int wm);
    bit ok;
    mem_phase(PF, o, wf, ok);
    if (!ok) return;
    push(PD, o);
    if (!legal(o)) return;
    case (o)
      OpLw:  begin push(PMa, o); mem_phase(PMr, o, wm, ok); if (ok) push(PMwb, o); end
      OpSw:  begin push(PMa, o); mem_phase(PMw, o, wm, ok); end
      OpR:   begin push(PEx, o); push(PAwb, o); end
      OpBeq: push(PBeq, o);
      OpImm: begin push(PExi, o); push(PAwb, o); end
      OpJal: begin push(PJal, o); push(PAwb, o); end
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return r % 4;
    case (r)
      14: return 13;
      15: return 14;
      16: return 15;
      17: return 16;
      default: return 20;
    endcase
  endfunction

  // Single driver of the DUT inputs; compares against the model while the queue runs.
  always @(negedge clk) begin
    if (active && q.size() != 0) begin
      cur = q.pop_front();
      op = cur.op; mem_ready = cur.rdy; zero_i = cur.z;
      #2;
      check($sformatf("model_%s", cur.ph.name()), got, expect_out(cur));
    end else begin
      op = man_op; mem_ready = man_rdy; zero_i = man_z;
    end
  end

  task automatic cyc(input logic [6:0] o, input bit rdy, input bit z);
    man_op = o; man_rdy = rdy; man_z = z;
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    man_op = OpSw; man_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("reset_low_outputs", {got[13:0], state_o}, '0);
    check("reset_low_strobes", got, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_first_edge_outputs", got, '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    op = OpSw; mem_ready = 1'b0; zero_i = 1'b0;
    do_reset();

    // R-type with ready memory, then an illegal opcode, then a hung fetch.
    cyc(OpR, 1, 0);
    check("r_fetch_strobes", {mem_req, IRWrite, PCWrite, ALUSrcB}, 18'b11110);
    cyc(OpR, 1, 0);
    check("r_decode_selects", {RegWrite, ALUSrcA, ALUSrcB}, 18'b00101);
    cyc(OpR, 1, 0);
    check("r_execr_aluop", {RegWrite, ALUOp, ALUSrcA}, 18'b01010);
    cyc(OpR, 1, 0);
    check("r_aluwb_regwrite", {RegWrite, mem_req, ResultSrc}, 18'b1000);
    cyc(7'h7f, 1, 0);
    check("ill_fetch", {mem_req, IRWrite, illegal_op}, 18'b110);
    cyc(7'h7f, 0, 0);
    check("ill_decode_pulse", {illegal_op, mem_req}, 18'b10);
    for (int i = 1; i <= 16; i++) begin
      cyc(7'h7f, 0, 0);
      if (i == 1)  check("ill_back_to_fetch", {illegal_op, mem_req}, 18'b01);
      if (i == 15) check("to_not_yet", {bus_err, mem_req}, 18'b01);
      if (i == 16) check("to_pulse", {bus_err, IRWrite, PCWrite, mem_req}, 18'b1001);
    end
    cyc(7'h7f, 0, 0);
    check("to_after_in_fetch", {bus_err, mem_req, ALUSrcB}, 18'b0110);

    // Randomized instruction stream against the model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = OpLw;
        1: o = OpSw;
        2: o = OpR;
        3: o = OpBeq;
        4: o = OpImm;
        5: o = OpJal;
        6: o = 7'h7f;
        default: o = 7'($urandom);
      endcase
      gen_instr(o, rand_wait(), rand_wait());
    end
    active = 1'b1;
    for (int i = 0; i < 60000 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    #1;
    active = 1'b0;

    // Asynchronous reset in the middle of a store.
    do_reset();
    cyc(OpSw, 1, 0);
    cyc(OpSw, 0, 0);
    cyc(OpSw, 0, 0);
    cyc(OpSw, 0, 0);
    check("sw_memwrite_active", {MemWrite, mem_req, AdrSrc}, 18'b111);
    rst_n = 1'b0;
    #1;
    check("sw_async_abort", {MemWrite, mem_req, AdrSrc}, 18'b000);
    man_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_before_edge", got, '0);
    cyc(OpSw, 1, 0);
    check("release_fetch", {mem_req, AdrSrc, MemWrite, IRWrite, ALUSrcB}, 18'b100110);
    cyc(OpSw, 0, 0);
    check("release_decode", {mem_req, MemWrite, ALUSrcA}, 18'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
